// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage with IF/ID register over a valid/ready instruction memory
// One request in flight at a time; bubbles are inserted while memory is slow.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        IReqValid,
  output logic [31:0] IReqAddr,
  input  logic        IReqReady,
  input  logic        IRspValid,
  input  logic [31:0] IRspData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        IMemWaitF
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic [31:0] pcf;
  logic        stale;
  logic [31:0] buf_data;

  logic        go;
  logic        handoff;
  logic [31:0] handoff_instr;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;

  assign go            = !StallF && !StallD;
  assign handoff       = go && !PCSrcE &&
                         ((state == S_WAIT && IRspValid && !stale) || state == S_HOLD);
  assign handoff_instr = (state == S_HOLD) ? buf_data : IRspData;
  assign pc_plus4      = pcf + 32'd4;
  assign redirect_pc   = PCTargetE & ~32'd3;

  // Gated by reset_n so no request is presented while the block is held in reset.
  assign IReqValid = (state == S_REQ) && reset_n;
  assign IReqAddr  = pcf;
  assign IMemWaitF = (state == S_WAIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_REQ;
      pcf      <= RESET_PC;
      stale    <= 1'b0;
      buf_data <= 32'd0;
    end else begin
      case (state)
        S_REQ: begin
          // A redirect racing the acceptance still sends the old PC; mark its reply stale.
          if (IReqReady) begin
            state <= S_WAIT;
            stale <= PCSrcE;
          end
        end
        S_WAIT: begin
          if (IRspValid) begin
            stale <= 1'b0;
            if (stale || PCSrcE || go) begin
              state <= S_REQ;
            end else begin
              state    <= S_HOLD;
              buf_data <= IRspData;
            end
          end else if (PCSrcE) begin
            stale <= 1'b1;
          end
        end
        S_HOLD: begin
          if (PCSrcE || go) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase

      if (PCSrcE)       pcf <= redirect_pc;
      else if (handoff) pcf <= pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      InstrD   <= NOP;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (handoff) begin
        InstrD   <= handoff_instr;
        PCD      <= pcf;
        PCPlus4D <= pc_plus4;
        ValidD   <= 1'b1;
      end else begin
        InstrD <= NOP;
        ValidD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed bench for fetch_stage with a transaction-level model
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'd0;
  logic        IReqValid, IReqReady = 1'b0, IRspValid = 1'b0;
  logic [31:0] IReqAddr, IRspData = 32'd0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, IMemWaitF;

  fetch_stage #(.RESET_PC(32'h0), .NOP(NOP)) dut (
    .clk(clk), .reset_n(reset_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .IReqValid(IReqValid), .IReqAddr(IReqAddr),
    .IReqReady(IReqReady), .IRspValid(IRspValid), .IRspData(IRspData), .InstrD(InstrD),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .IMemWaitF(IMemWaitF)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // memory environment
  int          lat = 1;
  int          rsp_cnt = 0;
  logic [31:0] rsp_addr = 32'd0;
  logic        rn = 1'b0;

  // model: one in-flight fetch (live or dead), at most one buffered word, and the decode view
  logic        m_busy, m_dead, m_has_buf, m_validd;
  logic [31:0] m_buf, m_pc, m_instr, m_pcd, m_pcp4;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return {a[19:0], 12'h013};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_dead = 0; m_has_buf = 0; m_buf = 0; m_pc = 0;
    m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_validd = 0;
  endtask

  task automatic model_step();
    logic        deliver, idle, go;
    logic [31:0] dw;
    if (!reset_n) begin
      model_reset();
      return;
    end
    deliver = 0; dw = 0;
    idle = !m_busy && !m_has_buf;
    go   = !StallF && !StallD;
    if (m_busy && IRspValid) begin
      m_busy = 0;
      if (!m_dead && !PCSrcE) begin
        if (go) begin deliver = 1; dw = IRspData; end
        else begin m_has_buf = 1; m_buf = IRspData; end
      end
      m_dead = 0;
    end else if (m_has_buf && !PCSrcE && go) begin
      deliver = 1; dw = m_buf; m_has_buf = 0;
    end
    if (PCSrcE) begin
      m_has_buf = 0;
      if (m_busy) m_dead = 1;
    end
    if (idle && IReqReady) begin
      m_busy = 1; m_dead = PCSrcE;
    end
    if (FlushD) begin
      m_instr = NOP; m_validd = 0;
    end else if (!StallD) begin
      if (deliver) begin
        m_instr = dw; m_pcd = m_pc; m_pcp4 = m_pc + 32'd4; m_validd = 1;
      end else begin
        m_instr = NOP; m_validd = 0;
      end
    end
    if (PCSrcE)       m_pc = PCTargetE & ~32'd3;
    else if (deliver) m_pc = m_pc + 32'd4;
  endtask

  task automatic check_outputs();
    logic exp_rv;
    exp_rv = reset_n && !m_busy && !m_has_buf;
    chk("IReqValid", {31'd0, IReqValid}, {31'd0, exp_rv});
    if (exp_rv) chk("IReqAddr", IReqAddr, m_pc);
    chk("IMemWaitF", {31'd0, IMemWaitF}, {31'd0, m_busy});
    chk("ValidD", {31'd0, ValidD}, {31'd0, m_validd});
    chk("InstrD", InstrD, m_instr);
    chk("PCD", PCD, m_pcd);
    chk("PCPlus4D", PCPlus4D, m_pcp4);
  endtask

  task automatic cyc(input logic sf, input logic sd, input logic fd, input logic ps,
                     input logic [31:0] tg, input logic rdy);
    logic        acc;
    logic [31:0] a;
    @(negedge clk);
    check_outputs();
    if (rsp_cnt == 1) begin
      IRspValid = 1; IRspData = instr_at(rsp_addr); rsp_cnt = 0;
    end else begin
      IRspValid = 0;
      if (rsp_cnt > 1) rsp_cnt--;
    end
    reset_n = rn; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tg;
    IReqReady = rdy;
    #1;
    acc = IReqValid && IReqReady && reset_n;
    a = IReqAddr;
    model_step();
    @(posedge clk);
    if (acc) begin rsp_cnt = lat; rsp_addr = a; end
  endtask

  task automatic run(input logic rdy);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, rdy);
  endtask

  logic [31:0] pq[$];
  logic [31:0] iq[$];
  int          tq[$];
  logic [31:0] hp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    rn = 0;
    repeat (3) run(1'b1);
    #1;
    chk("rst_IReqValid", {31'd0, IReqValid}, 32'd0);
    chk("rst_ValidD", {31'd0, ValidD}, 32'd0);
    chk("rst_InstrD", InstrD, NOP);

    rn = 1;
    run(1'b0);
    #1;
    chk("rel_IReqValid", {31'd0, IReqValid}, 32'd1);
    chk("rel_IReqAddr", IReqAddr, 32'h0);

    // streaming, 1-cycle memory
    for (int i = 0; i < 12; i++) begin
      run(1'b1);
      #1;
      if (ValidD) begin pq.push_back(PCD); iq.push_back(InstrD); tq.push_back(i); end
    end
    chk("stream_count", pq.size(), 32'd6);
    if (pq.size() >= 3) begin
      chk("stream_pc0", pq[0], 32'h0);
      chk("stream_pc1", pq[1], 32'h4);
      chk("stream_pc2", pq[2], 32'h8);
      chk("stream_i0", iq[0], 32'h0050_0093);
      chk("stream_i1", iq[1], 32'h0010_0113);
      chk("stream_gap", tq[1] - tq[0], 32'd2);
    end

    // stall while the response arrives
    for (int k = 0; k < 4 && rsp_cnt != 1; k++) run(1'b1);
    chk("stall_reach", {31'd0, rsp_cnt == 1}, 32'd1);
    hp = m_pc;
    chk("stall_pc", hp, 32'h18);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    #1;
    chk("stall_hold_noreq", {31'd0, IReqValid}, 32'd0);
    run(1'b1);
    #1;
    chk("stall_instr", InstrD, instr_at(32'h18));
    chk("stall_valid", {31'd0, ValidD}, 32'd1);
    chk("stall_next", IReqAddr, 32'h1C);

    // redirect while waiting on a slow response
    lat = 3;
    for (int k = 0; k < 6 && !(m_busy && rsp_cnt > 1); k++) run(1'b1);
    chk("redir_wait_reach", {31'd0, m_busy && rsp_cnt > 1}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
    for (int k = 0; k < 8 && m_busy; k++) run(1'b0);
    #1;
    chk("redir_wait_valid", {31'd0, IReqValid}, 32'd1);
    chk("redir_wait_addr", IReqAddr, 32'h100);
    chk("redir_wait_drop", {31'd0, ValidD}, 32'd0);

    // redirect in the same cycle the request is accepted
    lat = 1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b1);
    for (int k = 0; k < 8 && m_busy; k++) run(1'b0);
    #1;
    chk("redir_acc_valid", {31'd0, IReqValid}, 32'd1);
    chk("redir_acc_addr", IReqAddr, 32'h200);
    chk("redir_acc_drop", {31'd0, ValidD}, 32'd0);

    // flush on a handoff
    run(1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    #1;
    chk("flush_valid", {31'd0, ValidD}, 32'd0);
    chk("flush_instr", InstrD, NOP);
    chk("flush_pc_adv", IReqAddr, 32'h204);

    // redirect out of HOLD while stalled
    run(1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 1'b0);
    #1;
    chk("redir_hold_addr", IReqAddr, 32'h300);
    chk("redir_hold_wait", {31'd0, IMemWaitF}, 32'd0);
    run(1'b0);

    // PC wrap at the top of the address space
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    for (int k = 0; k < 6 && !m_validd; k++) run(1'b1);
    #1;
    chk("wrap_pcd", PCD, 32'hFFFF_FFFC);
    chk("wrap_pcp4", PCPlus4D, 32'h0);
    chk("wrap_next", IReqAddr, 32'h0);

    // asynchronous reset in the middle of WAIT
    lat = 3;
    for (int k = 0; k < 4 && !m_busy; k++) run(1'b1);
    chk("rstw_reach", {31'd0, m_busy}, 32'd1);
    #2;
    reset_n = 0; rn = 0; model_reset(); rsp_cnt = 0; IRspValid = 0;
    #1;
    chk("rstw_wait", {31'd0, IMemWaitF}, 32'd0);
    chk("rstw_req", {31'd0, IReqValid}, 32'd0);
    chk("rstw_valid", {31'd0, ValidD}, 32'd0);
    chk("rstw_instr", InstrD, NOP);
    chk("rstw_pcd", PCD, 32'h0);
    repeat (2) run(1'b0);
    rn = 1;
    lat = 1;
    run(1'b0);
    #1;
    chk("rstw_rel_addr", IReqAddr, 32'h0);
    chk("rstw_rel_valid", {31'd0, IReqValid}, 32'd1);
    repeat (6) run(1'b1);
    @(negedge clk);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
